// File: rtl/axi4_lite_master_bridge_if.sv
// Signal bundle between a native valid/ready memory port and an AXI4-Lite
// responder; the bridge uses the master view, the environment the slave view.
interface axi4_lite_master_bridge_if;
   logic        mem_valid;
   logic        mem_instr;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   logic        mem_axi_awvalid;
   logic        mem_axi_awready;
   logic [31:0] mem_axi_awaddr;
   logic [2:0]  mem_axi_awprot;

   logic        mem_axi_wvalid;
   logic        mem_axi_wready;
   logic [31:0] mem_axi_wdata;
   logic [3:0]  mem_axi_wstrb;

   logic        mem_axi_bvalid;
   logic        mem_axi_bready;

   logic        mem_axi_arvalid;
   logic        mem_axi_arready;
   logic [31:0] mem_axi_araddr;
   logic [2:0]  mem_axi_arprot;

   logic        mem_axi_rvalid;
   logic        mem_axi_rready;
   logic [31:0] mem_axi_rdata;

   modport master (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata,
      output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
      input  mem_axi_awready,
      output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
      input  mem_axi_wready,
      input  mem_axi_bvalid,
      output mem_axi_bready,
      output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
      input  mem_axi_arready,
      input  mem_axi_rvalid, mem_axi_rdata,
      output mem_axi_rready
   );

   modport slave (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata,
      input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
      output mem_axi_awready,
      input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
      output mem_axi_wready,
      output mem_axi_bvalid,
      input  mem_axi_bready,
      input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
      output mem_axi_arready,
      output mem_axi_rvalid, mem_axi_rdata,
      input  mem_axi_rready
   );
endinterface

// File: rtl/axi4_lite_master_bridge.sv
// Converts single native memory requests into one AXI4-Lite read or write at a
// time, with a sticky per-transaction watchdog flag.
module axi4_lite_master_bridge #(
   parameter int unsigned TIMEOUT = 32'd1024
) (
   input  logic                       clk,
   input  logic                       reset,
   axi4_lite_master_bridge_if.master  bus,
   output logic                       timeout_err
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [31:0] TMO_C = 32'(TIMEOUT);

   state_t      state_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  wstrb_q;
   logic [2:0]  arprot_q;
   logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q, mem_ready_q;
   logic        aw_done_q, w_done_q;
   logic [31:0] wd_q, wd_d;
   logic        timeout_err_q;
   logic        aw_now_s, w_now_s, wd_hit_s;

   // Write-channel progress including a handshake happening on this edge.
   always_comb begin
      aw_now_s = aw_done_q | (awvalid_q & bus.mem_axi_awready);
      w_now_s  = w_done_q  | (wvalid_q  & bus.mem_axi_wready);
   end

   // Transaction FSM; every bus-facing output is a register written here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         wstrb_q     <= 4'd0;
         arprot_q    <= 3'd0;
         rdata_q     <= 32'd0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         mem_ready_q <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.mem_valid) begin
                  addr_q <= bus.mem_addr;
                  if (bus.mem_wstrb == 4'd0) begin
                     arprot_q  <= {bus.mem_instr, 2'b00};
                     arvalid_q <= 1'b1;
                     state_q   <= RD_ADDR;
                  end else begin
                     wdata_q   <= bus.mem_wdata;
                     wstrb_q   <= bus.mem_wstrb;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_done_q <= 1'b0;
                     w_done_q  <= 1'b0;
                     state_q   <= WR_REQ;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            RD_ADDR: begin
               if (bus.mem_axi_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= RD_DATA;
               end else begin
                  state_q <= RD_ADDR;
               end
            end
            RD_DATA: begin
               // rready is only high here, so an early rvalid is never taken.
               if (bus.mem_axi_rvalid && rready_q) begin
                  rdata_q     <= bus.mem_axi_rdata;
                  rready_q    <= 1'b0;
                  mem_ready_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  state_q <= RD_DATA;
               end
            end
            WR_REQ: begin
               if (awvalid_q && bus.mem_axi_awready) begin
                  awvalid_q <= 1'b0;
               end
               if (wvalid_q && bus.mem_axi_wready) begin
                  wvalid_q <= 1'b0;
               end
               if (aw_now_s && w_now_s) begin
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  bready_q  <= 1'b1;
                  state_q   <= WR_RESP;
               end else begin
                  aw_done_q <= aw_now_s;
                  w_done_q  <= w_now_s;
                  state_q   <= WR_REQ;
               end
            end
            WR_RESP: begin
               if (bus.mem_axi_bvalid && bready_q) begin
                  bready_q    <= 1'b0;
                  mem_ready_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  state_q <= WR_RESP;
               end
            end
            DONE: begin
               mem_ready_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               arvalid_q   <= 1'b0;
               rready_q    <= 1'b0;
               awvalid_q   <= 1'b0;
               wvalid_q    <= 1'b0;
               bready_q    <= 1'b0;
               mem_ready_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   // Saturating watchdog increment and threshold detect.
   always_comb begin
      if (wd_q == 32'hFFFF_FFFF) begin
         wd_d = wd_q;
      end else begin
         wd_d = wd_q + 32'd1;
      end
      if ((TMO_C != 32'd0) && (wd_d >= TMO_C)) begin
         wd_hit_s = 1'b1;
      end else begin
         wd_hit_s = 1'b0;
      end
   end

   // Watchdog counts busy cycles; the flag is sticky until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_q          <= 32'd0;
         timeout_err_q <= 1'b0;
      end else if (state_q == IDLE) begin
         wd_q          <= 32'd0;
         timeout_err_q <= timeout_err_q;
      end else begin
         wd_q          <= wd_d;
         timeout_err_q <= timeout_err_q | wd_hit_s;
      end
   end

   assign bus.mem_ready       = mem_ready_q;
   assign bus.mem_rdata       = rdata_q;
   assign bus.mem_axi_awvalid = awvalid_q;
   assign bus.mem_axi_awaddr  = addr_q;
   assign bus.mem_axi_awprot  = 3'b000;
   assign bus.mem_axi_wvalid  = wvalid_q;
   assign bus.mem_axi_wdata   = wdata_q;
   assign bus.mem_axi_wstrb   = wstrb_q;
   assign bus.mem_axi_bready  = bready_q;
   assign bus.mem_axi_arvalid = arvalid_q;
   assign bus.mem_axi_araddr  = addr_q;
   assign bus.mem_axi_arprot  = arprot_q;
   assign bus.mem_axi_rready  = rready_q;
   assign timeout_err         = timeout_err_q;
endmodule

// File: doc/axi4_lite_master_bridge.md
AXI4_LITE_MASTER_BRIDGE -- requirements
Module: axi4_lite_master_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: watchdog limit in cycles per transaction; 0 disables the watchdog.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have native side ports: mem_valid in 1; mem_instr in 1; mem_ready out 1; mem_addr in 32; mem_wdata in 32; mem_wstrb in 4 (0 = read); mem_rdata out 32.
REQ-005 SHALL have AW ports: mem_axi_awvalid out 1; mem_axi_awready in 1; mem_axi_awaddr out 32; mem_axi_awprot out 3.
REQ-006 SHALL have W ports: mem_axi_wvalid out 1; mem_axi_wready in 1; mem_axi_wdata out 32; mem_axi_wstrb out 4.
REQ-007 SHALL have B ports: mem_axi_bvalid in 1; mem_axi_bready out 1.
REQ-008 SHALL have AR ports: mem_axi_arvalid out 1; mem_axi_arready in 1; mem_axi_araddr out 32; mem_axi_arprot out 3.
REQ-009 SHALL have R ports: mem_axi_rvalid in 1; mem_axi_rready out 1; mem_axi_rdata in 32.
REQ-010 SHALL have port timeout_err  output  1  sticky flag: some transaction exceeded TIMEOUT cycles.

Function
REQ-011 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE; all outputs registered.
REQ-012 IDLE: mem_valid=1 and mem_wstrb=0 -> latch addr/instr, next cycle arvalid=1, state RD_ADDR.
REQ-013 IDLE: mem_valid=1 and mem_wstrb!=0 -> latch addr/wdata/wstrb, next cycle awvalid=1 and wvalid=1, state WR_REQ.
REQ-014 araddr/awaddr SHALL equal the latched mem_addr unmodified; arprot = {mem_instr,2'b00}; awprot = 3'b000.
REQ-015 AXI address/data/prot outputs SHALL stay constant while their valid is high; valid SHALL NOT drop before its handshake.
REQ-016 RD_ADDR: arvalid&&arready at posedge -> arvalid=0, rready=1, state RD_DATA; arready without arvalid ignored.
REQ-017 RD_DATA: rvalid&&rready -> capture rdata into mem_rdata, rready=0, state DONE; rvalid arriving in same cycle as AR handshake is not sampled (rready still 0).
REQ-018 WR_REQ: AW and W handshakes tracked independently (aw_done, w_done); each valid drops the cycle after its own handshake; either order or same cycle allowed.
REQ-019 WR_REQ: once both done -> bready=1, state WR_RESP; bvalid before then not accepted.
REQ-020 WR_RESP: bvalid&&bready -> bready=0, state DONE.
REQ-021 DONE: mem_ready=1 for exactly one cycle, then IDLE; mem_valid ignored in DONE.
REQ-022 Minimum latency, zero-wait responder: mem_valid sample to mem_ready high = 4 cycles for read and write.
REQ-023 mem_rdata SHALL hold its value until the next read completes; writes leave it unchanged.
REQ-024 At most one outstanding transaction; no read and write overlap ever.
REQ-025 Watchdog: counter clears on leaving IDLE, increments each non-IDLE cycle, saturates; reaching TIMEOUT (TIMEOUT!=0) sets timeout_err; transaction NOT aborted.
REQ-026 mem_valid dropping mid-transaction SHALL NOT abort the AXI transaction; it completes and mem_ready still pulses.

Reset
REQ-027 reset=1 at posedge -> state IDLE; all valid/ready outputs 0, mem_ready=0, mem_rdata=0, timeout_err=0, watchdog=0, aw_done=w_done=0.
REQ-028 Reset mid-transaction SHALL drop all AXI valids next cycle without completing the transfer; responder-side cleanup is the environment's responsibility.
REQ-029 Reset has priority over every other event in the same cycle.

Verification
REQ-030 Read 0x00000010, mem_instr=1, zero-wait slave returning 0x12345678 -> araddr=0x10, arprot=3'b100, mem_ready after 4 cycles, mem_rdata=0x12345678.
REQ-031 Write 0x20000000 data 123456789 wstrb 4'hF, slave accepts W 3 cycles before AW -> wvalid drops first, awvalid holds until accepted, single B, one mem_ready pulse.
REQ-032 Byte write wstrb=4'b0100 to 0x104, data 0xAABBCCDD -> awaddr=0x104, wstrb=4'b0100, wdata=0xAABBCCDD unchanged, awprot=0.
REQ-033 Randomised arready/awready/wready/rvalid/bvalid delays (xorshift, 10000 transactions vs scoreboard) -> all data matches, no valid drops before handshake, no overlap.
REQ-034 TIMEOUT=16, slave never asserts rvalid -> timeout_err=1 at cycle 16, rready stays 1; later rvalid completes read, timeout_err stays 1 until reset.
REQ-035 reset asserted while awvalid=1 -> next cycle all valids/readies 0, state IDLE, subsequent read completes normally.
